fm_tx_mod: RTL and testbench
============================

# fm_tx_mod

Audio-to-RF FM modulator that drives the board's `fm_out` pin in the `clk_fm_send` domain (18.571429 MHz).
- Accepts signed 16-bit audio samples over a valid/ready handshake and linearly interpolates between them.
- Turns the interpolated value into a phase-accumulator frequency word around a fixed carrier.
- Emits the accumulator MSB as a 1-bit square-wave FM carrier.
- Replaces the constant `fm_out` driver in the top level; the audio source sits upstream, already synchronised to `clk_fm_send`.

## Interface
- `ACC_W`, 32: phase accumulator width.
- `CEN_FWORD`, 32'h2000_0000: carrier frequency word, giving fclk/8 ≈ 2.321 MHz.
- `DEV_SHIFT`, 8: left shift of the sample into the frequency word; ±32767 gives ≈ ±36.3 kHz deviation.
- `RAMP_SH`, 8: each interpolation segment lasts 2^RAMP_SH cycles.
- `STARVE_CYC`, 1024: idle cycles in WAIT/HOLD before `starved` asserts.
- `clk_fm_send` input 1: clock. Reset is `rst_n`, asynchronous, active-low.
- `rst_n` input 1: asynchronous active-low reset.
- `en` input 1: modulator enable, level.
- `s_data` input 16: signed audio sample.
- `s_valid` input 1: `s_data` is valid.
- `s_ready` output 1: a sample can be accepted this cycle.
- `fm_out` output 1: square-wave FM carrier.
- `starved` output 1: no sample has arrived for `STARVE_CYC` cycles.

## Operation
- **Buffer.** One-entry register `nxt` with flag `nxt_full`.
  - `s_ready = en && !nxt_full && state != OFF`.
  - A sample is accepted when `s_valid && s_ready`; `nxt_full` then sets on the next edge.
- **Interpolator.** `cur_fx` is signed, 16+RAMP_SH bits wide; `cur_int` is its top 16 bits.
- **Load** happens in any cycle with `nxt_full` where one of these holds:
  - state is WAIT or HOLD, or
  - state is RAMP and `cnt == 0`.
- **On load:**
  - `tgt <= nxt`
  - `step <= ({nxt, RAMP_SH'b0} - cur_fx) >>> RAMP_SH` (arithmetic shift)
  - `cnt <= 2^RAMP_SH - 1`
  - `nxt_full <= 0`
  - state goes to RAMP.
  - A load and an accept can never fall in the same cycle, because `s_ready` is low while `nxt_full` is set.
- **RAMP, each cycle:**
  - If `cnt != 0`: `cur_fx += step`, `cnt--`.
  - If `cnt == 0`: `cur_fx <= {tgt, 0}`, an exact snap that removes truncation error.
  - After the snap: load if `nxt_full`, otherwise go to HOLD.
- **States:**
  - OFF: `acc`, `fword`, `cur_fx`, `nxt_full` and `idle_cnt` are all cleared.
  - WAIT: enabled; `cur_fx = 0`; the carrier is unmodulated.
  - RAMP: interpolating toward `tgt`.
  - HOLD: `cur_fx` is held.
- **Transitions:**
  - OFF → WAIT when `en = 1`.
  - WAIT or HOLD → RAMP on load.
  - RAMP → RAMP or HOLD as described above.
  - Any state → OFF on the next edge when `en = 0`; this has priority over load and accept, and any buffered sample is discarded.
- **Starvation.**
  - `idle_cnt` increments each cycle in WAIT or HOLD and saturates at `STARVE_CYC`.
  - It clears on load.
  - `starved = (idle_cnt == STARVE_CYC)`, registered.
- **NCO.**
  - `fword <= CEN_FWORD + (sext(cur_int) << DEV_SHIFT)`, computed modulo 2^ACC_W and forced to 0 in OFF.
  - `acc <= acc + fword` each cycle, wrapping naturally.
  - `fm_out = acc[ACC_W-1]`, taken from the flop with no combinational logic after it.

## Timing
- Reset values:
  - `fm_out` = 0, `s_ready` = 0, `starved` = 0
  - state = OFF
  - `acc`, `fword`, `cur_fx` = 0
- Accept at edge T → `nxt_full` at T+1 → load at T+1 (from WAIT/HOLD) → first `cur_fx` update at T+2.
- `cur_fx == {sample, 0}` exactly at T+1+2^RAMP_SH.
- `s_ready` rises again at T+2.
- `cur_fx` change → `fword` 1 cycle later → `acc` 1 cycle after that → `fm_out` reflects it 2 cycles after the `cur_fx` change.
- At 48 kHz audio there are ≈387 cycles per sample, so with the default `RAMP_SH` each segment ends in HOLD for ≈131 cycles. This is normal and does not assert `starved`.
- Reset asserted mid-RAMP returns to the reset values asynchronously. After release, the first cycle is OFF.

## Structure
- Package `fm_tx_pkg` holds:
  - the state enum {OFF, WAIT, RAMP, HOLD}
  - `ACC_W`
  - the default `CEN_FWORD`
  - deviation/shift constants
- Sub-module `fm_nco`: fword register, accumulator, MSB output and OFF clear. The handshake, interpolator and FSM stay in `fm_tx_mod`.

## Test plan
- **Reset and idle carrier.** Reset, then `en = 1` with no samples.
  - `fm_out` has period 8 cycles, 4 low then 4 high; `s_ready = 1`.
  - `starved` rises 1024 cycles after WAIT entry.
- **Full-scale step.** Send +32767 (0x7FFF).
  - After the ramp, `cur_fx = 0x7FFF00` and `fword = 0x207F_FF00`.
  - Mid-ramp, after 255 steps, `cur_fx = 0x7F7F01`.
  - `starved` drops the cycle after load.
- **Back-to-back samples.** Hold `s_valid` high with 1000, -1000, 0.
  - The second load occurs in the same cycle as the first segment's snap, with no HOLD cycle.
  - `s_ready` is low exactly while `nxt_full` is set.
- **Negative extreme.** Send -32768.
  - Final `fword = 0x2000_0000 - 0x80_0000 = 0x1F80_0000`; the arithmetic-shifted step stays negative.
- **Disable mid-ramp.** Deassert `en` during RAMP with a sample buffered.
  - Next edge: OFF, `fm_out = 0`, `s_ready = 0`, buffer discarded.
  - Re-enable: starts in WAIT at `cur_fx = 0`.
- **Async reset mid-operation.** Pulse `rst_n` low during RAMP.
  - All outputs go to their reset values immediately.

Source files
------------

// File: rtl/fm_tx_pkg.sv
// Shared widths, default tuning constants and state encoding for the FM transmitter.
package fm_tx_pkg;

    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned ACC_W    = 32;

    // Carrier at fclk/8 with +-32767 mapping to roughly +-36 kHz of deviation
    localparam logic [ACC_W-1:0] FM_CEN_FWORD  = 32'h2000_0000;
    localparam int unsigned      FM_DEV_SHIFT  = 8;
    localparam int unsigned      FM_RAMP_SH    = 8;
    localparam int unsigned      FM_STARVE_CYC = 1024;

    localparam int unsigned ST_W = 2;
    typedef logic [ST_W-1:0] fm_state_t;

    localparam logic [ST_W-1:0] ST_OFF  = 2'd0;
    localparam logic [ST_W-1:0] ST_WAIT = 2'd1;
    localparam logic [ST_W-1:0] ST_RAMP = 2'd2;
    localparam logic [ST_W-1:0] ST_HOLD = 2'd3;

endpackage

// File: rtl/fm_tx_mod_nco.sv
// Phase-accumulator NCO: registered frequency word around the carrier, 1-bit MSB output.
module fm_nco
    import fm_tx_pkg::*;
#(
    parameter logic [ACC_W-1:0] CEN_FWORD = FM_CEN_FWORD,
    parameter int unsigned      DEV_SHIFT = FM_DEV_SHIFT
) (
    input  logic                       clk_fm_send,
    input  logic                       rst_n,
    input  logic                       clr_i,
    input  logic signed [SAMPLE_W-1:0] cur_int_i,
    output logic                       fm_out_o
);

    logic [ACC_W-1:0] fword_q, fword_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] dev_c;

    // Sign-extended deviation, wrapping modulo 2^ACC_W together with the carrier
    assign dev_c = {{(ACC_W-SAMPLE_W){cur_int_i[SAMPLE_W-1]}}, cur_int_i} << DEV_SHIFT;

    always_comb begin
        fword_d = CEN_FWORD + dev_c;
        acc_d   = acc_q + fword_q;
        if (clr_i) begin
            fword_d = '0;
            acc_d   = '0;
        end
    end

    always_ff @(posedge clk_fm_send or negedge rst_n) begin
        if (!rst_n) begin
            fword_q <= '0;
            acc_q   <= '0;
        end else begin
            fword_q <= fword_d;
            acc_q   <= acc_d;
        end
    end

    assign fm_out_o = acc_q[ACC_W-1];

endmodule

// File: rtl/fm_tx_mod.sv
// FM modulator top: sample handshake, linear interpolator and control FSM feeding the NCO.
module fm_tx_mod
    import fm_tx_pkg::*;
#(
    parameter logic [ACC_W-1:0] CEN_FWORD  = FM_CEN_FWORD,
    parameter int unsigned      DEV_SHIFT  = FM_DEV_SHIFT,
    parameter int unsigned      RAMP_SH    = FM_RAMP_SH,
    parameter int unsigned      STARVE_CYC = FM_STARVE_CYC
) (
    input  logic                       clk_fm_send,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic signed [SAMPLE_W-1:0] s_data,
    input  logic                       s_valid,
    output logic                       s_ready,
    output logic                       fm_out,
    output logic                       starved
);

    localparam int unsigned FX_W   = SAMPLE_W + RAMP_SH;
    localparam int unsigned DIFF_W = FX_W + 1;
    localparam int unsigned IDLE_W = $clog2(STARVE_CYC + 1);
    localparam logic [RAMP_SH-1:0] CNT_MAX  = '1;
    localparam logic [IDLE_W-1:0]  IDLE_MAX = IDLE_W'(STARVE_CYC);

    fm_state_t                   st_q, st_d;
    logic signed [SAMPLE_W-1:0]  nxt_q, nxt_d;
    logic                        nxt_full_q, nxt_full_d;
    logic signed [SAMPLE_W-1:0]  tgt_q, tgt_d;
    logic signed [FX_W-1:0]      cur_fx_q, cur_fx_d;
    logic signed [FX_W-1:0]      step_q, step_d;
    logic [RAMP_SH-1:0]          cnt_q, cnt_d;
    logic [IDLE_W-1:0]           idle_q, idle_d;
    logic                        starved_q, starved_d;

    logic                        accept_c;
    logic                        load_c;
    logic                        seg_end_c;
    logic                        idle_st_c;
    logic                        nco_clr_c;
    logic signed [FX_W-1:0]      tgt_fx_c;
    logic signed [FX_W-1:0]      nxt_fx_c;
    logic signed [FX_W-1:0]      base_fx_c;
    logic signed [DIFF_W-1:0]    diff_c;

    assign s_ready   = en && !nxt_full_q && (st_q != ST_OFF);
    assign accept_c  = s_valid && s_ready;
    assign idle_st_c = (st_q == ST_WAIT) || (st_q == ST_HOLD);
    assign seg_end_c = (st_q == ST_RAMP) && (cnt_q == '0);
    assign load_c    = nxt_full_q && (idle_st_c || seg_end_c);

    assign tgt_fx_c  = {tgt_q, {RAMP_SH{1'b0}}};
    assign nxt_fx_c  = {nxt_q, {RAMP_SH{1'b0}}};
    // A load coinciding with the snap must ramp from the exact snapped value
    assign base_fx_c = seg_end_c ? tgt_fx_c : cur_fx_q;
    // One extra bit so a full-scale swing cannot overflow before the shift
    assign diff_c    = $signed({nxt_fx_c[FX_W-1], nxt_fx_c})
                     - $signed({base_fx_c[FX_W-1], base_fx_c});

    always_comb begin
        st_d       = st_q;
        nxt_d      = nxt_q;
        nxt_full_d = nxt_full_q;
        tgt_d      = tgt_q;
        cur_fx_d   = cur_fx_q;
        step_d     = step_q;
        cnt_d      = cnt_q;
        idle_d     = idle_q;
        starved_d  = 1'b0;

        case (st_q)
            ST_OFF: begin
                st_d = ST_WAIT;
            end
            ST_RAMP: begin
                if (cnt_q != '0) begin
                    cur_fx_d = cur_fx_q + step_q;
                    cnt_d    = cnt_q - RAMP_SH'(1);
                end else begin
                    cur_fx_d = tgt_fx_c;
                    st_d     = ST_HOLD;
                end
            end
            default: begin
            end
        endcase

        if (idle_st_c && (idle_q != IDLE_MAX)) begin
            idle_d = idle_q + IDLE_W'(1);
        end

        if (accept_c) begin
            nxt_d      = s_data;
            nxt_full_d = 1'b1;
        end

        if (load_c) begin
            tgt_d      = nxt_q;
            step_d     = FX_W'(diff_c >>> RAMP_SH);
            cnt_d      = CNT_MAX;
            nxt_full_d = 1'b0;
            idle_d     = '0;
            st_d       = ST_RAMP;
        end

        // Disable wins over everything and drops any buffered sample
        if (!en) begin
            st_d       = ST_OFF;
            nxt_full_d = 1'b0;
            cur_fx_d   = '0;
            idle_d     = '0;
        end

        starved_d = (idle_d == IDLE_MAX);
    end

    always_ff @(posedge clk_fm_send or negedge rst_n) begin
        if (!rst_n) begin
            st_q       <= ST_OFF;
            nxt_q      <= '0;
            nxt_full_q <= 1'b0;
            tgt_q      <= '0;
            cur_fx_q   <= '0;
            step_q     <= '0;
            cnt_q      <= '0;
            idle_q     <= '0;
            starved_q  <= 1'b0;
        end else begin
            st_q       <= st_d;
            nxt_q      <= nxt_d;
            nxt_full_q <= nxt_full_d;
            tgt_q      <= tgt_d;
            cur_fx_q   <= cur_fx_d;
            step_q     <= step_d;
            cnt_q      <= cnt_d;
            idle_q     <= idle_d;
            starved_q  <= starved_d;
        end
    end

    assign starved   = starved_q;
    assign nco_clr_c = !en || (st_q == ST_OFF);

    fm_nco #(
        .CEN_FWORD (CEN_FWORD),
        .DEV_SHIFT (DEV_SHIFT)
    ) u_nco (
        .clk_fm_send (clk_fm_send),
        .rst_n       (rst_n),
        .clr_i       (nco_clr_c),
        .cur_int_i   (cur_fx_q[FX_W-1 -: SAMPLE_W]),
        .fm_out_o    (fm_out)
    );

endmodule

// File: tb/tb_fm_tx_mod.sv
// Self-checking bench for fm_tx_mod: directed scenarios plus random samples against a segment-level model.
module tb_fm_tx_mod;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        s_valid;
    logic [15:0] s_data;
    logic        s_ready;
    logic        fm_out;
    logic        starved;

    always #5 clk = ~clk;

    fm_tx_mod dut (
        .clk_fm_send (clk),
        .rst_n       (rst_n),
        .en          (en),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .fm_out      (fm_out),
        .starved     (starved)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: the output is a chain of linear segments between consecutive samples
    bit          m_on;
    bit          m_buf_full;
    longint      m_buf;
    bit          m_seg;
    int          m_e;
    longint      m_start;
    longint      m_step;
    longint      m_tgt;
    longint      m_cur;
    int          m_idle;
    logic [31:0] m_fword;
    logic [31:0] m_acc;
    bit          m_evt_acc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_on = 0; m_buf_full = 0; m_buf = 0; m_seg = 0; m_e = 0;
        m_start = 0; m_step = 0; m_tgt = 0; m_cur = 0; m_idle = 0;
        m_fword = '0; m_acc = '0; m_evt_acc = 0;
    endtask

    task automatic model_edge();
        bit     ready;
        bit     accept;
        bit     load;
        bit     seg_end;
        longint cur_int;
        m_evt_acc = 0;
        if (!en) begin
            model_reset();
            return;
        end
        if (!m_on) begin
            m_on = 1;
            return;
        end
        ready   = !m_buf_full;
        accept  = s_valid && ready;
        seg_end = m_seg && (m_e == 255);
        load    = m_buf_full && (!m_seg || seg_end);
        cur_int = m_cur >>> 8;
        m_acc   = m_acc + m_fword;
        m_fword = 32'(64'h2000_0000 + cur_int * 256);
        if (!m_seg) m_idle = (m_idle < 1024) ? m_idle + 1 : 1024;
        if (m_seg) begin
            m_e++;
            if (m_e == 256) begin
                m_cur = m_tgt * 256;
                m_seg = 0;
            end else begin
                m_cur = m_start + longint'(m_e) * m_step;
            end
        end
        if (load) begin
            m_start    = m_tgt * 256;
            m_step     = (m_buf * 256 - m_start) >>> 8;
            m_tgt      = m_buf;
            m_seg      = 1;
            m_e        = 0;
            m_cur      = m_start;
            m_buf_full = 0;
            m_idle     = 0;
        end
        if (accept) begin
            m_buf      = longint'($signed(s_data));
            m_buf_full = 1;
            m_evt_acc  = 1;
        end
    endtask

    task automatic check_all();
        chk("fm_out",  64'(fm_out),  64'(m_acc[31]));
        chk("s_ready", 64'(s_ready), 64'(en && m_on && !m_buf_full));
        chk("starved", 64'(starved), 64'(m_idle == 1024));
        chk("cur_fx",  64'({dut.cur_fx_q}), 64'(m_cur[23:0]));
        chk("fword",   64'(dut.u_nco.fword_q), 64'(m_fword));
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic send_one(input logic [15:0] v);
        s_data  = v;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          first_starve;
        int          highs;
        int          rises;
        logic        prev;
        int          idx;
        int          low_cnt;
        logic [15:0] vals [3];

        rst_n = 1'b0; en = 1'b0; s_valid = 1'b0; s_data = '0;
        model_reset();
        repeat (3) tick();
        chk("rst_acc", 64'(dut.u_nco.acc_q), 64'd0);
        chk("rst_fm_out", 64'(fm_out), 64'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Idle carrier and starvation onset
        en = 1'b1;
        first_starve = -1;
        for (int i = 1; i <= 1100; i++) begin
            tick();
            if (starved && first_starve < 0) first_starve = i;
        end
        chk("starve_latency", 64'(first_starve), 64'd1025);
        highs = 0; rises = 0; prev = fm_out;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (fm_out) highs++;
            if (fm_out && !prev) rises++;
            prev = fm_out;
        end
        chk("idle_high_cycles", 64'(highs), 64'd32);
        chk("idle_periods", 64'(rises), 64'd8);

        // Full-scale positive step
        send_one(16'h7FFF);
        tick();
        chk("starve_drop", 64'(starved), 64'd0);
        repeat (255) tick();
        chk("mid_ramp_cur", 64'({dut.cur_fx_q}), 64'h7F7F01);
        tick();
        chk("final_cur", 64'({dut.cur_fx_q}), 64'h7FFF00);
        tick();
        chk("final_fword", 64'(dut.u_nco.fword_q), 64'h207F_FF00);
        repeat (200) tick();

        // Back-to-back samples with s_valid held high
        vals[0] = 16'(1000); vals[1] = 16'(-1000); vals[2] = 16'(0);
        idx = 0; low_cnt = 0;
        s_data = vals[0]; s_valid = 1'b1;
        for (int i = 0; i < 900; i++) begin
            tick();
            if (!s_ready) low_cnt++;
            if (m_evt_acc) begin
                idx++;
                if (idx < 3) s_data = vals[idx];
                else s_valid = 1'b0;
            end
        end
        chk("b2b_accepts", 64'(idx), 64'd3);
        chk("b2b_ready_low", 64'(low_cnt), 64'd511);
        chk("b2b_final_cur", 64'({dut.cur_fx_q}), 64'd0);

        // Negative extreme
        send_one(16'h8000);
        tick();
        chk("neg_step_sign", 64'(dut.step_q[23]), 64'd1);
        repeat (256) tick();
        chk("neg_final_cur", 64'({dut.cur_fx_q}), 64'h80_0000);
        tick();
        chk("neg_final_fword", 64'(dut.u_nco.fword_q), 64'h1F80_0000);
        repeat (50) tick();

        // Random samples and gaps, including full-scale swings
        for (int n = 0; n < 25; n++) begin
            repeat ($urandom_range(0, 420)) tick();
            case ($urandom_range(0, 3))
                0:       s_data = 16'h7FFF;
                1:       s_data = 16'h8000;
                default: s_data = 16'($urandom);
            endcase
            s_valid = 1'b1;
            for (int w = 0; w < 600 && s_valid; w++) begin
                tick();
                if (m_evt_acc) s_valid = 1'b0;
            end
            chk("accept_timeout", 64'(s_valid), 64'd0);
            s_valid = 1'b0;
        end
        repeat (300) tick();

        // Disable mid-ramp with a sample buffered
        send_one(16'(12345));
        tick();
        repeat (10) tick();
        send_one(16'(-777));
        repeat (5) tick();
        en = 1'b0;
        tick();
        chk("dis_fm_out", 64'(fm_out), 64'd0);
        chk("dis_s_ready", 64'(s_ready), 64'd0);
        chk("dis_buffer", 64'(dut.nxt_full_q), 64'd0);
        repeat (3) tick();
        en = 1'b1;
        tick();
        chk("reen_cur", 64'({dut.cur_fx_q}), 64'd0);
        repeat (300) tick();
        chk("reen_no_stale", 64'({dut.cur_fx_q}), 64'd0);

        // Asynchronous reset in the middle of a ramp
        send_one(16'(20000));
        repeat (60) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_fm_out", 64'(fm_out), 64'd0);
        chk("arst_s_ready", 64'(s_ready), 64'd0);
        chk("arst_starved", 64'(starved), 64'd0);
        chk("arst_cur", 64'({dut.cur_fx_q}), 64'd0);
        chk("arst_acc", 64'(dut.u_nco.acc_q), 64'd0);
        chk("arst_fword", 64'(dut.u_nco.fword_q), 64'd0);
        model_reset();
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (40) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
